vrased_reset_ctrl: RTL and testbench
====================================

VRASED_RESET_CTRL -- requirements
Module: vrased_reset_ctrl

Interface
REQ-001 Parameter RESET_HANDLER, default 16'h0000: PC value at which the reset handler is deemed entered.
REQ-002 Parameter HOLD_CYCLES, default 8, legal range 1..255: number of cycles cpu_reset is held per violation.
REQ-003 Parameter WAIT_TIMEOUT, default 64, legal range 1..255: maximum number of cycles spent in WAIT_PC before re-reset.
REQ-004 Parameter CNT_W, default 8: width of viol_count.
REQ-005 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 Port pc, input, 16: current CPU program counter.
REQ-008 Port viol, input, 6: per-monitor violation flags; bit0 X_stack, bit1 AC, bit2 atomicity, bit3 dma_AC, bit4 dma_detect, bit5 dma_X_stack.
REQ-009 Port clear_log, input, 1: single-cycle request to clear cause and viol_count.
REQ-010 Port cpu_reset, output, 1: registered reset request to the CPU, active-high.
REQ-011 Port busy, output, 1: high in any state other than RUN.
REQ-012 Port cause, output, 6: sticky OR of all violation bits seen since the last clear.
REQ-013 Port viol_count, output, CNT_W: saturating count of reset entries.

Function
REQ-014 The FSM SHALL have three states: RUN, HOLD and WAIT_PC, encoded in a 2-bit register.
REQ-015 In RUN, when |viol=1 at a clock edge, the FSM SHALL move to HOLD, set cpu_reset=1 at that same edge (1-cycle latency from viol to cpu_reset) and load hold_cnt=HOLD_CYCLES-1.
REQ-016 In HOLD, cpu_reset SHALL stay 1; hold_cnt SHALL decrement each cycle; when hold_cnt=0 and viol=0, the FSM SHALL move to WAIT_PC, clear cpu_reset and load wait_cnt=WAIT_TIMEOUT-1; cpu_reset is therefore high for exactly HOLD_CYCLES cycles.
REQ-017 In HOLD, |viol=1 SHALL reload hold_cnt=HOLD_CYCLES-1, extending the hold; no new count increment occurs.
REQ-018 In WAIT_PC, pc==RESET_HANDLER with viol=0 SHALL return the FSM to RUN on the next edge.
REQ-019 In WAIT_PC, |viol=1 SHALL take priority over the pc match: the FSM returns to HOLD as in REQ-015, counted as a new entry.
REQ-020 In WAIT_PC, when wait_cnt=0 without a pc match, the FSM SHALL return to HOLD (timeout re-reset) and set cause bit nothing new, but SHALL increment viol_count.
REQ-021 Each entry into HOLD from RUN or WAIT_PC SHALL increment viol_count, saturating at all-ones.
REQ-022 cause SHALL OR in viol every cycle, in every state.
REQ-023 When clear_log=1 and viol=0, cause and viol_count SHALL be cleared; when both occur in the same cycle, cause SHALL equal viol and viol_count SHALL equal the new-entry value (1 if an entry occurs, else 0).
REQ-024 busy SHALL be a decode of the state register: 0 in RUN, 1 in HOLD and WAIT_PC.

Reset
REQ-025 reset_n=0 SHALL asynchronously force: state=RUN, cpu_reset=0, busy=0, cause=0, viol_count=0, hold_cnt=0, wait_cnt=0.
REQ-026 Assertion of reset_n mid-HOLD SHALL abort the hold immediately; after release, the FSM starts in RUN with no memory of the prior violation.

Configuration
REQ-027 Macro VRASED_CAUSE_LOG_EN defined: cause, viol_count and clear_log behave per REQ-021..REQ-023.
REQ-028 Macro VRASED_CAUSE_LOG_EN undefined: cause and viol_count SHALL be constant 0, clear_log SHALL be ignored, no log registers are synthesised, and FSM and cpu_reset behaviour SHALL be unchanged.

Structure
REQ-029 The following SHALL live in shared package vrased_pkg: the state encoding (RUN=2'd0, HOLD=2'd1, WAIT_PC=2'd2), the viol bit-index constants and the default RESET_HANDLER.
REQ-030 The saturating counter SHALL be one sub-module, vrased_sat_cnt (parameter W; inputs inc and clr; output q), instantiated only when VRASED_CAUSE_LOG_EN is defined.

Verification
REQ-031 Scenario 1: pulse viol=6'b000100 for one cycle in RUN -> cpu_reset high on the next edge for exactly 8 cycles; cause=6'h04; viol_count=1.
REQ-032 Scenario 2: after the hold ends, drive pc=16'h0000 on the 3rd cycle of WAIT_PC -> busy=0 on the following edge.
REQ-033 Scenario 3: assert viol=6'b000001 during hold cycle 5 -> the hold is extended to 8 cycles past that point; viol_count stays 1.
REQ-034 Scenario 4: keep pc!=RESET_HANDLER for 64 WAIT_PC cycles -> cpu_reset re-asserts; viol_count=2.
REQ-035 Scenario 5: assert clear_log together with viol=6'b100000 -> cause=6'h20 and viol_count=1; with the macro undefined, both outputs read 0 throughout.
REQ-036 Scenario 6: drive reset_n low during HOLD -> cpu_reset=0 asynchronously; with 256+ violations applied and CNT_W=8, viol_count saturates at 8'hFF.

Source files
------------

// File: rtl/vrased_pkg.sv
// vrased_pkg: shared state encoding, violation bit indices and reset-handler default for the VRASED reset controller.
package vrased_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HOLD    = 2'd1,
        WAIT_PC = 2'd2
    } state_t;

    localparam int VIOL_W           = 6;
    localparam int VIOL_X_STACK     = 0;
    localparam int VIOL_AC          = 1;
    localparam int VIOL_ATOMICITY   = 2;
    localparam int VIOL_DMA_AC      = 3;
    localparam int VIOL_DMA_DETECT  = 4;
    localparam int VIOL_DMA_X_STACK = 5;

    localparam logic [15:0] DEFAULT_RESET_HANDLER = 16'h0000;

endpackage

// File: rtl/vrased_sat_cnt.sv
// vrased_sat_cnt: saturating up-counter with synchronous clear; an increment in the clear cycle lands as 1.
module vrased_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            q <= '0;
        else if (clr)
            q <= W'(inc);
        else if (inc && q != {W{1'b1}})
            q <= q + W'(1);

endmodule

// File: rtl/vrased_reset_ctrl.sv
// vrased_reset_ctrl: holds the CPU in reset after a monitor violation, then waits for the reset handler PC.
// Cause/count logging is built only when VRASED_CAUSE_LOG_EN is defined.
module vrased_reset_ctrl
    import vrased_pkg::*;
#(
    parameter logic [15:0] RESET_HANDLER = DEFAULT_RESET_HANDLER,
    parameter int          HOLD_CYCLES   = 8,
    parameter int          WAIT_TIMEOUT  = 64,
    parameter int          CNT_W         = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       pc,
    input  logic [VIOL_W-1:0] viol,
    input  logic              clear_log,
    output logic              cpu_reset,
    output logic              busy,
    output logic [VIOL_W-1:0] cause,
    output logic [CNT_W-1:0]  viol_count
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] hold_cnt, hold_nxt, wait_cnt, wait_nxt;
    logic       any_viol, pc_hit, entry;

    assign any_viol = |viol;
    assign pc_hit   = pc == RESET_HANDLER;
    assign busy     = state != RUN;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
            hold_cnt  <= '0;
            wait_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            cpu_reset <= state_nxt == HOLD;
            hold_cnt  <= hold_nxt;
            wait_cnt  <= wait_nxt;
        end

    // A violation always wins over the PC match; a timeout re-enters HOLD as a fresh entry.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        wait_nxt  = wait_cnt;
        entry     = 1'b0;
        case (state)
            RUN:
                if (any_viol) begin
                    state_nxt = HOLD;
                    hold_nxt  = HOLD_LOAD;
                    entry     = 1'b1;
                end
            HOLD:
                if (any_viol)
                    hold_nxt = HOLD_LOAD;
                else if (hold_cnt == 8'd0) begin
                    state_nxt = WAIT_PC;
                    wait_nxt  = WAIT_LOAD;
                end else
                    hold_nxt = hold_cnt - 8'd1;
            WAIT_PC:
                if (any_viol || (!pc_hit && wait_cnt == 8'd0)) begin
                    state_nxt = HOLD;
                    hold_nxt  = HOLD_LOAD;
                    entry     = 1'b1;
                end else if (pc_hit)
                    state_nxt = RUN;
                else
                    wait_nxt = wait_cnt - 8'd1;
            default:
                state_nxt = RUN;
        endcase
    end

`ifdef VRASED_CAUSE_LOG_EN
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            cause <= '0;
        else
            cause <= (clear_log ? '0 : cause) | viol;

    vrased_sat_cnt #(.W(CNT_W)) u_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (entry),
        .clr    (clear_log),
        .q      (viol_count)
    );
`else
    logic unused_log;
    assign unused_log = &{1'b0, clear_log, entry};
    assign cause      = '0;
    assign viol_count = '0;
`endif

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// tb_vrased_reset_ctrl: directed scenarios plus random traffic against a cycle-count reference model.
module tb_vrased_reset_ctrl;
    import vrased_pkg::*;

    localparam int H = 8;
    localparam int W = 64;
`ifdef VRASED_CAUSE_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] pc = 16'h1234;
    logic [5:0]  viol = '0;
    logic        clear_log = 1'b0;
    logic        cpu_reset, busy;
    logic [5:0]  cause;
    logic [7:0]  viol_count;

    int n_vec = 0, n_fail = 0;
    int m_left = 0, m_wait = 0, m_cnt = 0;
    logic [5:0] m_cause = '0;

    vrased_reset_ctrl dut (
        .clk(clk), .reset_n(reset_n), .pc(pc), .viol(viol), .clear_log(clear_log),
        .cpu_reset(cpu_reset), .busy(busy), .cause(cause), .viol_count(viol_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_left = 0; m_wait = 0; m_cnt = 0; m_cause = '0;
    endtask

    // m_left: reset cycles still owed to the CPU; m_wait: WAIT_PC cycles left before timeout.
    task automatic model_edge();
        bit entry = 1'b0;
        if (m_left > 0) begin
            if (viol != 0) m_left = H;
            else begin
                m_left--;
                if (m_left == 0) m_wait = W;
            end
        end else if (m_wait > 0) begin
            if (viol != 0) begin m_wait = 0; m_left = H; entry = 1'b1; end
            else if (pc == DEFAULT_RESET_HANDLER) m_wait = 0;
            else begin
                m_wait--;
                if (m_wait == 0) begin m_left = H; entry = 1'b1; end
            end
        end else if (viol != 0) begin
            m_left = H; entry = 1'b1;
        end
        m_cause = (clear_log ? 6'h00 : m_cause) | viol;
        m_cnt = clear_log ? int'(entry) : (m_cnt + int'(entry) > 255 ? 255 : m_cnt + int'(entry));
    endtask

    task automatic chk_model();
        chk("cpu_reset", 32'(cpu_reset), 32'(m_left > 0));
        chk("busy", 32'(busy), 32'(m_left > 0 || m_wait > 0));
        chk("cause", 32'(cause), LOG ? 32'(m_cause) : 32'h0);
        chk("viol_count", 32'(viol_count), LOG ? 32'(m_cnt) : 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk_model();
    endtask

    task automatic run_out_hold(output int n);
        n = 0;
        while (cpu_reset && n < 300) begin
            n++;
            step();
        end
    endtask

    int n;

    initial begin
        #2;
        chk("rst_cpu_reset", 32'(cpu_reset), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cause", 32'(cause), 0);
        chk("rst_count", 32'(viol_count), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        step();

        // Scenario 1: single atomicity pulse
        viol = 6'(1 << VIOL_ATOMICITY);
        step();
        viol = '0;
        chk("s1_latency", 32'(cpu_reset), 1);
        run_out_hold(n);
        chk("s1_hold_len", 32'(n), H);
        chk("s1_cause", 32'(cause), LOG ? 32'h04 : 0);
        chk("s1_count", 32'(viol_count), LOG ? 32'd1 : 0);

        // Scenario 2: handler reached on 3rd WAIT_PC cycle
        step(); step();
        chk("s2_still_busy", 32'(busy), 1);
        pc = 16'h0000;
        step();
        chk("s2_busy_clear", 32'(busy), 0);
        pc = 16'h4321;

        // Scenario 3: hold extension at hold cycle 5
        clear_log = 1'b1;
        step();
        clear_log = 1'b0;
        viol = 6'(1 << VIOL_DMA_DETECT);
        step();
        viol = '0;
        repeat (4) step();
        viol = 6'(1 << VIOL_X_STACK);
        step();
        viol = '0;
        run_out_hold(n);
        chk("s3_ext_len", 32'(n), H);
        chk("s3_count", 32'(viol_count), LOG ? 32'd1 : 0);

        // Scenario 4: WAIT_PC timeout re-reset
        repeat (W - 1) step();
        chk("s4_pre_timeout", 32'(cpu_reset), 0);
        step();
        chk("s4_rereset", 32'(cpu_reset), 1);
        chk("s4_count", 32'(viol_count), LOG ? 32'd2 : 0);

        // Scenario 5: clear coinciding with a new violation
        run_out_hold(n);
        pc = 16'h0000;
        step();
        pc = 16'h5555;
        chk("s5_run", 32'(busy), 0);
        clear_log = 1'b1;
        viol = 6'(1 << VIOL_DMA_X_STACK);
        step();
        clear_log = 1'b0;
        viol = '0;
        chk("s5_cause", 32'(cause), LOG ? 32'h20 : 0);
        chk("s5_count", 32'(viol_count), LOG ? 32'd1 : 0);

        // Scenario 6: asynchronous abort mid-hold, then saturation
        step(); step();
        reset_n = 1'b0;
        #1;
        chk("s6_async_cpu_reset", 32'(cpu_reset), 0);
        chk("s6_async_busy", 32'(busy), 0);
        chk("s6_async_count", 32'(viol_count), 0);
        model_reset();
        #2 reset_n = 1'b1;
        step();
        chk("s6_run_after", 32'(busy), 0);
        for (int i = 0; i < 260; i++) begin
            viol = 6'(1 << VIOL_AC);
            step();
            viol = '0;
            run_out_hold(n);
        end
        chk("s6_saturated", 32'(viol_count), LOG ? 32'hFF : 0);

        // Random traffic
        clear_log = 1'b1;
        step();
        for (int i = 0; i < 3000; i++) begin
            viol      = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
            pc        = ($urandom_range(0, 11) == 0) ? 16'h0000 : 16'($urandom);
            clear_log = $urandom_range(0, 15) == 0;
            step();
        end
        clear_log = 1'b0;
        viol = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
